// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
//   Round-robin arbiter and sequencer for the 16:1 structural mux datapath.
//   Grants one of 16 requesters, drives the registered 4-bit select of the
//   mux16to1 instance, holds it for the whole transaction and re-arbitrates
//   only after the owner releases (done pulse or request withdrawal).
//
// Optional feature (macro MUX16_ARB_TIMEOUT_EN):
//   When defined, a CNT_W-bit hold counter forces a release once a grant
//   has been held for TIMEOUT BUSY cycles and pulses timeout for one cycle.
//   When undefined, no counter is built and timeout is tied to 0.
//
// Parameters:
//   CNT_W    width of the optional hold-timeout counter
//   TIMEOUT  BUSY cycles before a forced release (1 .. 2^CNT_W-1)
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous, active-high reset
//   req      in   16  level-sensitive per-channel request
//   done     in   1   end-of-transaction pulse from the current owner
//   grant    out  16  registered one-hot grant, zero when idle
//   sel      out  4   registered index of the granted channel (mux select)
//   valid    out  1   registered, high while a grant is held
//   timeout  out  1   registered one-cycle pulse on forced release
module mux16_rr_arbiter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  sel,
  output logic        valid,
  output logic        timeout
);

  if (TIMEOUT < 1 || TIMEOUT > (2 ** CNT_W) - 1) begin : g_param_check
    $error("mux16_rr_arbiter: TIMEOUT must be in 1 .. 2^CNT_W-1");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_ptr,   w_ptr_nx;
  logic [15:0] r_grant, w_grant_nx;
  logic [3:0]  r_sel,   w_sel_nx;
  logic        r_valid, w_valid_nx;
  logic        w_release;
  logic        w_force;
  logic [3:0]  w_pick;

  // First requesting channel scanning ptr, ptr+1, ... ptr+15 (mod 16).
  function automatic logic [3:0] f_rr_pick(input logic [15:0] f_req,
                                           input logic [3:0]  f_ptr);
    logic [3:0] idx;
    logic       hit;
    f_rr_pick = f_ptr;
    hit       = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = f_ptr + 4'(i);
      if (!hit && f_req[idx]) begin
        f_rr_pick = idx;
        hit       = 1'b1;
      end
    end
  endfunction

  assign w_pick    = f_rr_pick(req, r_ptr);
  // Owner ends the transaction either by pulsing done or by dropping its request.
  assign w_release = done | ~req[r_sel];

`ifdef MUX16_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_timeout_nx;

  assign w_force      = (r_cnt == CNT_W'(TIMEOUT));
  // A normal release in the same cycle wins, so no timeout pulse then.
  assign w_timeout_nx = (r_state == S_BUSY) & w_force & ~w_release;

  // Counter is held at zero while idle, so it starts from zero on BUSY entry;
  // it saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_nx;
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_grant_nx = r_grant;
    w_sel_nx   = r_sel;
    w_valid_nx = r_valid;
    case (r_state)
      S_IDLE: begin
        // sel keeps its last value while idle so the mux input stays put.
        w_grant_nx = '0;
        w_valid_nx = 1'b0;
        if (|req) begin
          w_grant_nx = 16'h0001 << w_pick;
          w_sel_nx   = w_pick;
          w_valid_nx = 1'b1;
          w_state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        // Other channels are not sampled here; no preemption.
        if (w_release || w_force) begin
          w_grant_nx = '0;
          w_valid_nx = 1'b0;
          w_ptr_nx   = r_sel + 4'd1;
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = '0;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 4'h0;
      r_grant <= 16'h0000;
      r_sel   <= 4'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_grant <= w_grant_nx;
      r_sel   <= w_sel_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = r_valid;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] req  = 16'hFFFF;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        valid;
  logic        timeout;

  mux16_rr_arbiter #(.CNT_W(8), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected grant event: channel and number of idle (valid=0) cycles
  // immediately before it (-1 = not checked).
  typedef struct {
    logic [3:0] sel;
    int         gap;
  } exp_t;
  exp_t q[$];

  logic mon_en     = 1'b0;
  int   idle_cnt   = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input int gap);
    exp_t e;
    e.sel = s;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: invariants every cycle; grant events popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
      chk("inv_grant_iff_valid", 32'(grant != 16'h0), 32'(valid));
      if (valid === 1'b1) chk("inv_grant_sel", 32'(grant[sel]), 32'd1);
      if (valid === 1'b1 && prev_valid !== 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got sel %0d, expected no grant (t=%0t)", sel, $time);
        end else begin
          e = q.pop_front();
          chk("grant_sel", 32'(sel), 32'(e.sel));
          chk("grant_vec", 32'(grant), 32'(16'h0001 << e.sel));
          if (e.gap >= 0) chk("idle_gap", idle_cnt, e.gap);
        end
      end
      idle_cnt   <= (valid === 1'b1) ? 0 : idle_cnt + 1;
      prev_valid <= valid;
    end
  end

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid: got no grant within 50 cycles, expected one (t=%0t)", $time);
    end
  endtask

  // Pulse done one cycle after the grant; nreq is applied with the done pulse
  // (simul=1) or right after the release edge (simul=0).
  task automatic release_txn(input logic [15:0] nreq, input bit simul);
    @(posedge clk); #1;
    done = 1'b1;
    if (simul) req = nreq;
    @(posedge clk); #1;
    done = 1'b0;
    req  = nreq;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requests asserted.
    rst = 1'b1;
    req = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
    end
    push(4'd0, -1);
    rst = 1'b0;
    wait_valid();
    release_txn(16'hFFFF, 1'b0);

    // Round robin 1..15 then wrap to 0.
    for (int k = 1; k <= 16; k++) begin
      push(4'(k % 16), 1);
      wait_valid();
      release_txn((k == 16) ? 16'h4000 : 16'hFFFF, 1'b0);
    end

    // ptr=1 -> channel 14; release leaves ptr=15; 0x0009 wraps to 0 then 3.
    push(4'd14, 1);
    wait_valid();
    release_txn(16'h0009, 1'b0);
    push(4'd0, 1);
    wait_valid();
    release_txn(16'h0009, 1'b0);
    push(4'd3, 1);
    wait_valid();
    release_txn(16'h0020, 1'b0);

    // Channel 5 holds while 7 requests; withdrawal releases without done.
    push(4'd5, 1);
    wait_valid();
    @(posedge clk); #1;
    req = 16'h00A0;
    @(negedge clk);
    chk("hold_sel_a", 32'(sel), 32'd5);
    chk("hold_valid_a", 32'(valid), 32'd1);
    @(posedge clk); #1;
    req = 16'h0080;
    push(4'd7, 1);
    @(negedge clk);
    chk("hold_sel_b", 32'(sel), 32'd5);
    chk("hold_valid_b", 32'(valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("withdraw_valid", 32'(valid), 32'd0);
    chk("withdraw_sel_held", 32'(sel), 32'd5);
    wait_valid();
    release_txn(16'h0200, 1'b0);

    // Reset in the middle of channel 9's transaction.
    push(4'd9, 1);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_sel", 32'(sel), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    push(4'd9, 1);
    rst = 1'b0;
    wait_valid();

    // done together with withdrawal: single pointer advance (ptr=10 -> ch 10, not 11).
    release_txn(16'h0C00, 1'b1);
    push(4'd10, 1);
    wait_valid();
    release_txn(16'h000C, 1'b0);

    // Channel 2 granted and done never asserted.
    push(4'd2, 1);
    wait_valid();
`ifdef MUX16_ARB_TIMEOUT_EN
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("to_hold_valid", 32'(valid), 32'd1);
      chk("to_hold_pulse", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("to_release_valid", 32'(valid), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    push(4'd3, 1);
    wait_valid();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    req = 16'h0000;
`else
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk("nto_hold_valid", 32'(valid), 32'd1);
      chk("nto_hold_sel", 32'(sel), 32'd2);
      chk("nto_timeout", 32'(timeout), 32'd0);
    end
    @(posedge clk); #1;
    req = 16'h0000;
`endif
    @(posedge clk);
    @(negedge clk);
    chk("final_release", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
